// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared definitions for the I-cache / LSU memory arbiter.
//   - arb_state_e    : arbiter FSM state encoding
//   - GNT_IC, GNT_LS : grant-ID constants held in the last-grant register
//   - BEAT_W         : width of the beat counter and of the burst length field
//   - next_beat_addr : address of the following beat (incrementing or fixed)
package ysyx_25040111_mem_arbiter_pkg;

  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IC = 2'd1,
    ST_GNT_LS = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_LS = 1'b1;

  // A fixed-address burst keeps the base address; otherwise step one word.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr, input logic burst);
    logic [31:0] nxt;
    if (burst) begin
      nxt = addr;
    end else begin
      nxt = addr + 32'd4;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_25040111_rr_arb2.sv
// Two-way request picker.
//   req_ic, req_ls : pending requests
//   last_gnt       : requester granted most recently (GNT_IC / GNT_LS)
//   prio_ls        : 1 = LSU always wins a tie, 0 = round-robin on a tie
//   gnt            : one-hot grant, bit 0 = I-cache, bit 1 = LSU
module ysyx_25040111_rr_arb2
  import ysyx_25040111_mem_arbiter_pkg::*;
(
  input  logic       req_ic,
  input  logic       req_ls,
  input  logic       last_gnt,
  input  logic       prio_ls,
  output logic [1:0] gnt
);

  // Pick a single winner; on a tie the loser of the previous round wins
  // unless fixed LSU priority is selected.
  always_comb begin
    gnt = 2'b00;
    if (req_ic && req_ls) begin
      if (prio_ls) begin
        gnt = 2'b10;
      end else if (last_gnt == GNT_LS) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else if (req_ic) begin
      gnt = 2'b01;
    end else if (req_ls) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Arbitrates one downstream memory port between the I-cache refill path
// (multi-beat bursts) and the LSU (single beats).
//   clock, reset               : clock, synchronous active-high reset
//   ic_valid/addr/len/burst    : I-cache request (len = beats-1), held to final beat
//   ic_ready/data/err          : per-beat ack, data and error pulse to the I-cache
//   ls_valid/wen/addr/wdata/wstrb : LSU single-beat request, held until ls_ready
//   ls_ready/rdata/err         : LSU completion, read data and error pulse
//   m_valid/addr/len/burst/wen/wdata/wstrb : downstream request
//   m_ready/rdata/err          : downstream per-beat ack, data and error
// A granted transaction is followed by one TURN cycle before re-arbitration.
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter int LS_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_valid,
  input  logic [31:0]       ic_addr,
  input  logic [BEAT_W-1:0] ic_len,
  input  logic              ic_burst,
  output logic              ic_ready,
  output logic [31:0]       ic_data,
  output logic              ic_err,
  input  logic              ls_valid,
  input  logic              ls_wen,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_wstrb,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              m_valid,
  output logic [31:0]       m_addr,
  output logic [BEAT_W-1:0] m_len,
  output logic              m_burst,
  output logic              m_wen,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,
  input  logic              m_err
);

  arb_state_e        state_r, state_s;
  logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_s;
  logic              last_gnt_r, last_gnt_s;
  logic [31:0]       addr_r, addr_s;
  logic [BEAT_W-1:0] len_r, len_s;
  logic              burst_r, burst_s;
  logic              wen_r, wen_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [3:0]        wstrb_r, wstrb_s;
  logic [1:0]        gnt_s;
  logic              prio_ls_s;
  logic              own_ic_s, own_ls_s;

  assign prio_ls_s = (LS_PRIO != 0);

  ysyx_25040111_rr_arb2 u_pick (
    .req_ic   (ic_valid),
    .req_ls   (ls_valid),
    .last_gnt (last_gnt_r),
    .prio_ls  (prio_ls_s),
    .gnt      (gnt_s)
  );

  // Control state: FSM, beat counter and last-grant register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= '0;
      last_gnt_r <= GNT_LS;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      last_gnt_r <= last_gnt_s;
    end
  end

  // Latched request fields; only meaningful while a grant is active.
  always_ff @(posedge clock) begin
    addr_r  <= addr_s;
    len_r   <= len_s;
    burst_r <= burst_s;
    wen_r   <= wen_s;
    wdata_r <= wdata_s;
    wstrb_r <= wstrb_s;
  end

  // Next-state logic: grant in IDLE, count beats while granted, one TURN cycle.
  always_comb begin
    state_s    = state_r;
    beat_cnt_s = beat_cnt_r;
    last_gnt_s = last_gnt_r;
    addr_s     = addr_r;
    len_s      = len_r;
    burst_s    = burst_r;
    wen_s      = wen_r;
    wdata_s    = wdata_r;
    wstrb_s    = wstrb_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s[0]) begin
          state_s    = ST_GNT_IC;
          addr_s     = ic_addr;
          len_s      = ic_len;
          burst_s    = ic_burst;
          wen_s      = 1'b0;
          wdata_s    = 32'h0000_0000;
          wstrb_s    = 4'h0;
          beat_cnt_s = '0;
          last_gnt_s = prio_ls_s ? last_gnt_r : GNT_IC;
        end else if (gnt_s[1]) begin
          state_s    = ST_GNT_LS;
          addr_s     = ls_addr;
          len_s      = '0;
          burst_s    = 1'b0;
          wen_s      = ls_wen;
          wdata_s    = ls_wdata;
          wstrb_s    = ls_wstrb;
          beat_cnt_s = '0;
          last_gnt_s = prio_ls_s ? last_gnt_r : GNT_LS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GNT_IC, ST_GNT_LS: begin
        if (m_ready) begin
          beat_cnt_s = beat_cnt_r + 8'd1;
          addr_s     = next_beat_addr(addr_r, burst_r);
          // An error aborts any remaining beats.
          if (m_err || (beat_cnt_r == len_r)) begin
            state_s = ST_TURN;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_TURN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Responses are masked while reset is high so an abandoned beat never pulses.
  assign own_ic_s = (state_r == ST_GNT_IC) && !reset;
  assign own_ls_s = (state_r == ST_GNT_LS) && !reset;

  assign ic_ready = m_ready && !m_err && own_ic_s;
  assign ic_err   = m_ready && m_err && own_ic_s;
  assign ic_data  = m_rdata;
  assign ls_ready = m_ready && !m_err && own_ls_s;
  assign ls_err   = m_ready && m_err && own_ls_s;
  assign ls_rdata = m_rdata;

  assign m_valid = (state_r == ST_GNT_IC) || (state_r == ST_GNT_LS);
  assign m_addr  = addr_r;
  assign m_len   = len_r;
  assign m_burst = burst_r;
  assign m_wen   = wen_r;
  assign m_wdata = wdata_r;
  assign m_wstrb = wstrb_r;

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Directed bench: round-robin instance "dut" and fixed-LSU-priority "dut_p"
// share all inputs; each step drives inputs just after a rising edge and
// checks outputs before the next one.
module tb_ysyx_25040111_mem_arbiter;
  import ysyx_25040111_mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ic_valid, ic_burst, ls_valid, ls_wen, m_ready, m_err;
  logic [31:0] ic_addr, ls_addr, ls_wdata, m_rdata;
  logic [7:0]  ic_len;
  logic [3:0]  ls_wstrb;

  logic        ic_ready, ic_err, ls_ready, ls_err, m_valid, m_burst, m_wen;
  logic [31:0] ic_data, ls_rdata, m_addr, m_wdata;
  logic [7:0]  m_len;
  logic [3:0]  m_wstrb;

  logic        p_ic_ready, p_ic_err, p_ls_ready, p_ls_err, p_m_valid, p_m_burst, p_m_wen;
  logic [31:0] p_ic_data, p_ls_rdata, p_m_addr, p_m_wdata;
  logic [7:0]  p_m_len;
  logic [3:0]  p_m_wstrb;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  ysyx_25040111_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_len(ic_len), .ic_burst(ic_burst),
    .ic_ready(ic_ready), .ic_data(ic_data), .ic_err(ic_err),
    .ls_valid(ls_valid), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .m_valid(m_valid), .m_addr(m_addr), .m_len(m_len), .m_burst(m_burst), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err)
  );

  ysyx_25040111_mem_arbiter #(.LS_PRIO(1)) dut_p (
    .clock(clock), .reset(reset),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_len(ic_len), .ic_burst(ic_burst),
    .ic_ready(p_ic_ready), .ic_data(p_ic_data), .ic_err(p_ic_err),
    .ls_valid(ls_valid), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_ready(p_ls_ready), .ls_rdata(p_ls_rdata), .ls_err(p_ls_err),
    .m_valid(p_m_valid), .m_addr(p_m_addr), .m_len(p_m_len), .m_burst(p_m_burst), .m_wen(p_m_wen),
    .m_wdata(p_m_wdata), .m_wstrb(p_m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    ic_valid = 1'b0; ic_addr = 32'h0; ic_len = 8'd0; ic_burst = 1'b0;
    ls_valid = 1'b0; ls_wen = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
    m_ready = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    m_ready = 1'b1;
    #1;
    // reset state
    chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_cnt", 32'(dut.beat_cnt_r), 32'd0);
    chk("rst_last", 32'(dut.last_gnt_r), 32'(GNT_LS));
    chk("rst_ic_ready", 32'(ic_ready), 32'd0);
    m_ready = 1'b0;
    tick();
    reset = 1'b0;

    // IC only, fixed-address burst of two beats
    ic_valid = 1'b1; ic_addr = 32'h3000_0010; ic_len = 8'd1; ic_burst = 1'b1;
    #1;
    chk("t30_latency", 32'(m_valid), 32'd0);
    tick();
    chk("t30_state", 32'(dut.state_r), 32'(ST_GNT_IC));
    chk("t30_m_addr", m_addr, 32'h3000_0010);
    chk("t30_m_len", 32'(m_len), 32'd1);
    chk("t30_m_wen", 32'(m_wen), 32'd0);
    m_ready = 1'b1; m_rdata = 32'h0000_00A0;
    #1;
    chk("t30_ready0", 32'(ic_ready), 32'd1);
    chk("t30_data0", ic_data, 32'h0000_00A0);
    chk("t30_ls_ready", 32'(ls_ready), 32'd0);
    tick();
    m_rdata = 32'h0000_00A1;
    #1;
    chk("t30_addr1", m_addr, 32'h3000_0010);
    chk("t30_ready1", 32'(ic_ready), 32'd1);
    tick();
    ic_valid = 1'b0;
    #1;
    chk("t30_turn", 32'(dut.state_r), 32'(ST_TURN));
    chk("t30_m_valid_low", 32'(m_valid), 32'd0);
    chk("t30_turn_ignore", 32'(ic_ready), 32'd0);
    tick();
    m_ready = 1'b0;
    chk("t30_idle", 32'(dut.state_r), 32'(ST_IDLE));

    // both valid after reset: IC first, then LSU read
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ic_valid = 1'b1; ic_addr = 32'h0000_0100; ic_len = 8'd0; ic_burst = 1'b0;
    ls_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h0000_0200;
    tick();
    chk("t31_first", 32'(dut.state_r), 32'(ST_GNT_IC));
    chk("t31_ic_addr", m_addr, 32'h0000_0100);
    m_ready = 1'b1; m_rdata = 32'h0000_0011;
    #1;
    chk("t31_ic_ready", 32'(ic_ready), 32'd1);
    chk("t31_ls_hidden", 32'(ls_ready), 32'd0);
    tick();
    ic_valid = 1'b0; m_ready = 1'b0;
    chk("t31_turn", 32'(dut.state_r), 32'(ST_TURN));
    tick();
    chk("t31_idle", 32'(m_valid), 32'd0);
    tick();
    chk("t31_ls_gnt", 32'(dut.state_r), 32'(ST_GNT_LS));
    chk("t31_ls_addr", m_addr, 32'h0000_0200);
    chk("t31_ls_len", 32'(m_len), 32'd0);
    m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t31_ls_ready", 32'(ls_ready), 32'd1);
    chk("t31_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
    chk("t31_ic_hidden", 32'(ic_ready), 32'd0);
    tick();
    ls_valid = 1'b0; m_ready = 1'b0;
    tick();

    // IC incrementing burst of four beats with one wait cycle
    ic_valid = 1'b1; ic_addr = 32'h0000_0000; ic_len = 8'd3; ic_burst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        m_ready = 1'b0;
        #1;
        chk("t32_wait_ready", 32'(ic_ready), 32'd0);
        tick();
        chk("t32_wait_addr", m_addr, 32'h0000_0008);
      end
      m_ready = 1'b1;
      #1;
      chk("t32_addr", m_addr, 32'(i * 4));
      chk("t32_ready", 32'(ic_ready), 32'd1);
      tick();
    end
    ic_valid = 1'b0; m_ready = 1'b0;
    chk("t32_done", 32'(m_valid), 32'd0);
    chk("t32_turn", 32'(dut.state_r), 32'(ST_TURN));
    tick();

    // LSU write with error on its beat
    ls_valid = 1'b1; ls_wen = 1'b1; ls_addr = 32'h0000_0040;
    ls_wdata = 32'h1234_5678; ls_wstrb = 4'hF;
    tick();
    chk("t33_wen", 32'(m_wen), 32'd1);
    chk("t33_wdata", m_wdata, 32'h1234_5678);
    chk("t33_wstrb", 32'(m_wstrb), 32'hF);
    chk("t33_burst", 32'(m_burst), 32'd0);
    m_ready = 1'b1; m_err = 1'b1;
    #1;
    chk("t33_ls_err", 32'(ls_err), 32'd1);
    chk("t33_ls_ready", 32'(ls_ready), 32'd0);
    chk("t33_ic_err", 32'(ic_err), 32'd0);
    tick();
    ls_valid = 1'b0; m_ready = 1'b0; m_err = 1'b0;
    #1;
    chk("t33_turn", 32'(dut.state_r), 32'(ST_TURN));
    chk("t33_err_pulse", 32'(ls_err), 32'd0);
    tick();
    chk("t33_idle", 32'(dut.state_r), 32'(ST_IDLE));

    // IC error on beat 1 aborts the rest of the burst
    ic_valid = 1'b1; ic_addr = 32'h0000_0300; ic_len = 8'd3; ic_burst = 1'b1;
    tick();
    m_ready = 1'b1;
    tick();
    m_err = 1'b1;
    #1;
    chk("ierr_err", 32'(ic_err), 32'd1);
    chk("ierr_ready", 32'(ic_ready), 32'd0);
    tick();
    ic_valid = 1'b0; m_ready = 1'b0; m_err = 1'b0;
    chk("ierr_abort", 32'(m_valid), 32'd0);
    tick();

    // reset during beat 2 of a four-beat IC burst
    ic_valid = 1'b1; ic_addr = 32'h0000_0080; ic_len = 8'd3; ic_burst = 1'b0;
    tick();
    m_ready = 1'b1;
    tick();
    chk("t34_addr1", m_addr, 32'h0000_0084);
    tick();
    reset = 1'b1;
    #1;
    chk("t34_addr2", m_addr, 32'h0000_0088);
    chk("t34_no_ready", 32'(ic_ready), 32'd0);
    chk("t34_no_err", 32'(ic_err), 32'd0);
    tick();
    chk("t34_m_valid", 32'(m_valid), 32'd0);
    chk("t34_cnt", 32'(dut.beat_cnt_r), 32'd0);
    reset = 1'b0; m_ready = 1'b0;
    ic_addr = 32'h0000_0500; ic_len = 8'd0;
    tick();
    chk("t34_regrant", m_addr, 32'h0000_0500);
    m_ready = 1'b1;
    #1;
    chk("t34_ready", 32'(ic_ready), 32'd1);
    tick();
    ic_valid = 1'b0; m_ready = 1'b0;
    tick();

    // round-robin fairness: IC was last, so LSU wins, then IC
    ic_valid = 1'b1; ic_addr = 32'h0000_0700; ic_len = 8'd0;
    ls_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h0000_0600;
    tick();
    chk("rr_ls_first", m_addr, 32'h0000_0600);
    m_ready = 1'b1;
    #1;
    chk("rr_ls_ready", 32'(ls_ready), 32'd1);
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    chk("rr_ic_next", m_addr, 32'h0000_0700);
    chk("rr_ic_state", 32'(dut.state_r), 32'(ST_GNT_IC));
    m_ready = 1'b1;
    tick();
    clear_inputs();
    tick();

    // fixed LSU priority with both requesters continuously valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ic_valid = 1'b1; ic_addr = 32'h0000_0900; ic_len = 8'd0;
    ls_valid = 1'b1; ls_addr = 32'h0000_0A00;
    m_ready = 1'b1;
    tick();
    chk("t35_gnt1", 32'(dut_p.state_r), 32'(ST_GNT_LS));
    chk("t35_ls_ready", 32'(p_ls_ready), 32'd1);
    chk("t35_ic_hidden", 32'(p_ic_ready), 32'd0);
    tick();
    tick();
    tick();
    chk("t35_gnt2", 32'(dut_p.state_r), 32'(ST_GNT_LS));
    chk("t35_addr2", p_m_addr, 32'h0000_0A00);
    tick();
    ls_valid = 1'b0;
    tick();
    tick();
    chk("t35_ic_gnt", 32'(dut_p.state_r), 32'(ST_GNT_IC));
    chk("t35_ic_ready", 32'(p_ic_ready), 32'd1);
    chk("t35_ic_addr", p_m_addr, 32'h0000_0900);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_mem_arbiter.md
YSYX_25040111_MEM_ARBITER -- requirements
Module: ysyx_25040111_mem_arbiter

Interface
REQ-001 Parameter LS_PRIO, default 0; 0 selects round-robin, 1 selects fixed LSU priority.
REQ-002 clock  in  1  system clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 ic_valid in 1, ic_addr in 32, ic_len in 8 (beats-1), ic_burst in 1: I-cache refill request, held until final beat.
REQ-005 ic_ready out 1, ic_data out 32, ic_err out 1: per-beat ack, beat data, error pulse to I-cache.
REQ-006 ls_valid in 1, ls_wen in 1, ls_addr in 32, ls_wdata in 32, ls_wstrb in 4: LSU single-beat request, held until ls_ready.
REQ-007 ls_ready out 1, ls_rdata out 32, ls_err out 1: LSU completion pulse, read data, error pulse.
REQ-008 m_valid out 1, m_addr out 32, m_len out 8, m_burst out 1, m_wen out 1, m_wdata out 32, m_wstrb out 4: downstream request.
REQ-009 m_ready in 1, m_rdata in 32, m_err in 1: downstream per-beat ack, data, error.

Function
REQ-010 FSM states IDLE, GNT_IC, GNT_LS, TURN; encoding from shared package.
REQ-011 IDLE: if any valid, select winner, latch its addr/len/burst/wen/wdata/wstrb, go to GNT_x; m_valid rises the next cycle (1-cycle grant latency).
REQ-012 Round-robin: on tie, grant the requester not granted last; last-grant register resets to LSU, so IC wins the first tie.
REQ-013 LS_PRIO=1: LSU wins every tie; last-grant register unused.
REQ-014 LSU grant: m_len=0, m_burst=0, m_wen=ls_wen; IC grant: m_len=ic_len, m_burst=ic_burst, m_wen=0, m_wstrb=0.
REQ-015 m_valid stays 1 throughout GNT_x until the final beat (m_ready with beat counter == m_len); it drops the following cycle.
REQ-016 8-bit beat counter clears at grant, increments on each m_ready; completion uses counter, not an external last signal.
REQ-017 IC grant with m_burst=0: m_addr increments by 4 after each m_ready beat; with m_burst=1 m_addr holds the base.
REQ-018 ic_ready = m_ready & (state==GNT_IC); ic_data = m_rdata; combinational, same cycle.
REQ-019 ls_ready = m_ready & (state==GNT_LS); ls_rdata = m_rdata; combinational, same cycle.
REQ-020 Non-granted requester sees ready=0 and err=0 regardless of m_ready.
REQ-021 After completion, FSM enters TURN for exactly one cycle, then IDLE; no back-to-back grant without turnaround.
REQ-022 m_err with m_ready: pulse owner's err for that cycle (ready not asserted), abort remaining beats, go to TURN.
REQ-023 Requester dropping valid mid-transaction is illegal; arbiter completes the latched transaction regardless.
REQ-024 m_ready while IDLE or TURN is ignored.
REQ-025 Fairness: under round-robin a waiting requester is granted after at most one transaction of the other.

Reset
REQ-026 Reset forces IDLE, m_valid=0, counter=0, last-grant=LSU, all ready/err outputs 0, effective on the same edge.
REQ-027 Reset mid-transaction abandons it with no ready or err pulse; latched request fields need no reset.

Structure
REQ-028 Shared package holds FSM state encoding, grant-ID constants (GNT_IC, GNT_LS) and beat-width constant (8).
REQ-029 Two-way picker (ysyx_25040111_rr_arb2: two requests, last-grant, prio mode, one-hot grant) is a separate sub-module.

Verification
REQ-030 IC only, addr 0x3000_0010, len 1, burst 1 -> m_addr 0x3000_0010, m_len 1, two ic_ready pulses, m_valid low after beat 2, one TURN cycle.
REQ-031 IC and LSU valid same cycle after reset -> IC granted first; LSU granted after IC finish + TURN; LSU read returns m_rdata 0xDEAD_BEEF on ls_rdata.
REQ-032 IC burst 0, len 3, base 0x0 -> m_addr sequence 0x0, 0x4, 0x8, 0xC; four ic_ready pulses.
REQ-033 LSU write 0x1234_5678 wstrb 0xF, m_err on its beat -> ls_err pulse 1 cycle, ls_ready 0, FSM to TURN then IDLE.
REQ-034 Reset asserted during beat 2 of a len-3 IC burst -> m_valid 0 next edge, no ic_ready/ic_err; fresh request afterwards granted normally.
REQ-035 LS_PRIO=1, both valid continuously -> LSU granted on every arbitration; IC granted only when ls_valid low.
